// File: rtl/kernel_mhsa_mul_pkg.sv
// Width, rounding and saturation helpers shared by the MHSA multiplier pipe.
// All helpers are constant functions, usable in parameter and index expressions.
package kernel_mhsa_mul_pkg;

   function automatic int prod_width(input int w0, input int w1);
      return w0 + w1;
   endfunction

   // Half of one output LSB, added before the arithmetic shift (round-half-up).
   function automatic longint round_const(input int shift);
      if (shift > 0)
         return 64'sd1 <<< (shift - 1);
      return 64'sd0;
   endfunction

   function automatic longint sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

   function automatic int lane_lsb(input int lane, input int w);
      return lane * w;
   endfunction

endpackage

// File: rtl/kernel_mhsa_mul_lane.sv
// One signed multiply lane: exact product, optional round-half-up shift, narrow to DOUT_WIDTH.
// Purely combinational; clamps and flags ovf when KERNEL_MHSA_MUL_SAT_EN is defined, wraps otherwise.
module kernel_mhsa_mul_lane
   import kernel_mhsa_mul_pkg::*;
#(
   parameter int DIN0_WIDTH = 10,
   parameter int DIN1_WIDTH = 36,
   parameter int DOUT_WIDTH = 36,
   parameter int SHIFT      = 0
) (
   input  logic signed [DIN0_WIDTH-1:0] din0,
   input  logic signed [DIN1_WIDTH-1:0] din1,
   output logic        [DOUT_WIDTH-1:0] dout,
   output logic                         ovf
);

   localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

   logic signed [PW-1:0] p;
   logic signed [PW:0]   r;

   assign p = din0 * din1;

   // One extra bit of headroom keeps the rounding add from overflowing.
   generate
      if (SHIFT > 0) begin : g_rnd
         localparam logic signed [PW:0] RND = (PW+1)'(round_const(SHIFT));
         assign r = ($signed({p[PW-1], p}) + RND) >>> SHIFT;
      end else begin : g_nornd
         assign r = {p[PW-1], p};
      end
   endgenerate

`ifdef KERNEL_MHSA_MUL_SAT_EN
   localparam logic signed [PW:0] MAXV = (PW+1)'(sat_max(DOUT_WIDTH));
   localparam logic signed [PW:0] MINV = (PW+1)'(sat_min(DOUT_WIDTH));

   always_comb begin
      dout = r[DOUT_WIDTH-1:0];
      ovf  = 1'b0;
      if (r > MAXV) begin
         dout = MAXV[DOUT_WIDTH-1:0];
         ovf  = 1'b1;
      end else if (r < MINV) begin
         dout = MINV[DOUT_WIDTH-1:0];
         ovf  = 1'b1;
      end
   end
`else
   logic unused_r;
   assign unused_r = ^r;
   assign dout     = r[DOUT_WIDTH-1:0];
   assign ovf      = 1'b0;
`endif

endmodule

// File: rtl/kernel_mhsa_mul_pipe.sv
// LANES-wide signed multiplier, NUM_STAGE-cycle latency, valid/ready with full back-pressure (bubbles collapse).
// Sticky per-lane overflow flags exist only when KERNEL_MHSA_MUL_SAT_EN is defined.
module kernel_mhsa_mul_pipe
   import kernel_mhsa_mul_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int DIN0_WIDTH = 10,
   parameter int DIN1_WIDTH = 36,
   parameter int DOUT_WIDTH = 36,
   parameter int SHIFT      = 0,
   parameter int NUM_STAGE  = 2
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*DIN0_WIDTH-1:0]   din0,
   input  logic [LANES*DIN1_WIDTH-1:0]   din1,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*DOUT_WIDTH-1:0]   dout,
   output logic [LANES-1:0]              ovf_sticky,
   input  logic                          ovf_clr,
   output logic                          busy
);

   localparam int DW = LANES * DOUT_WIDTH;
   localparam int LS = NUM_STAGE - 1;

   logic [DW-1:0]                 cap_dat;
   logic [LANES-1:0]              lane_ovf;
   logic [NUM_STAGE-1:0]          v;
   logic [NUM_STAGE-1:0]          free;
   logic [NUM_STAGE-1:0][DW-1:0]  sd;
   logic                          accept;

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         kernel_mhsa_mul_lane #(
            .DIN0_WIDTH (DIN0_WIDTH),
            .DIN1_WIDTH (DIN1_WIDTH),
            .DOUT_WIDTH (DOUT_WIDTH),
            .SHIFT      (SHIFT)
         ) u_lane (
            .din0 (din0[lane_lsb(i, DIN0_WIDTH) +: DIN0_WIDTH]),
            .din1 (din1[lane_lsb(i, DIN1_WIDTH) +: DIN1_WIDTH]),
            .dout (cap_dat[lane_lsb(i, DOUT_WIDTH) +: DOUT_WIDTH]),
            .ovf  (lane_ovf[i])
         );
      end
   endgenerate

   // Stage k can take a new beat if it or any later stage has a hole, or the sink drains.
   always_comb begin : p_free
      logic open_slot;
      free      = '0;
      open_slot = out_ready;
      for (int k = NUM_STAGE - 1; k >= 0; k--) begin
         open_slot = open_slot || !v[k];
         free[k]   = open_slot;
      end
   end

   assign in_ready  = ap_rst_n && free[0];
   assign accept    = in_valid && in_ready;
   assign out_valid = v[LS];
   assign dout      = sd[LS];
   assign busy      = |v;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         v  <= '0;
         sd <= '0;
      end else begin
         if (free[0])
            v[0] <= accept;
         if (accept)
            sd[0] <= cap_dat;
         for (int k = 1; k < NUM_STAGE; k++) begin
            if (free[k])
               v[k] <= v[k-1];
            if (free[k] && v[k-1])
               sd[k] <= sd[k-1];
         end
      end
   end

`ifdef KERNEL_MHSA_MUL_SAT_EN
   // A clamp on the capturing beat beats a same-cycle clear.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)
         ovf_sticky <= '0;
      else
         ovf_sticky <= (ovf_clr ? '0 : ovf_sticky) | (accept ? lane_ovf : '0);
   end
`else
   logic unused_ovf;
   assign unused_ovf = ^{ovf_clr, lane_ovf};
   assign ovf_sticky = '0;
`endif

endmodule

// File: tb/tb_kernel_mhsa_mul_pipe.sv
// Directed bench for kernel_mhsa_mul_pipe: SHIFT=0 and SHIFT=4 instances share one handshake.
// Expected results track KERNEL_MHSA_MUL_SAT_EN the same way the design does.
module tb_kernel_mhsa_mul_pipe;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic          ovf_clr = 1'b0;
   logic [39:0]   din0 = '0;
   logic [143:0]  din1 = '0;

   logic          in_ready0, out_valid0, busy0;
   logic [143:0]  dout0;
   logic [3:0]    ovf0;
   logic          in_ready4, out_valid4, busy4;
   logic [143:0]  dout4;
   logic [3:0]    ovf4;

   kernel_mhsa_mul_pipe #(.SHIFT(0)) u_dut0 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .din0(din0), .din1(din1), .out_valid(out_valid0), .out_ready(out_ready),
      .dout(dout0), .ovf_sticky(ovf0), .ovf_clr(ovf_clr), .busy(busy0));

   kernel_mhsa_mul_pipe #(.SHIFT(4)) u_dut4 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .din0(din0), .din1(din1), .out_valid(out_valid4), .out_ready(out_ready),
      .dout(dout4), .ovf_sticky(ovf4), .ovf_clr(ovf_clr), .busy(busy4));

   always #5 ap_clk = ~ap_clk;

   int            nchecks = 0;
   int            nerr = 0;
   int            pops = 0;
   int            cyc = 0;
   int            first_pop = -1;
   int            last_pop = -1;
   logic [143:0]  exp0_q[$];
   logic [143:0]  exp4_q[$];
   logic          acc_flag;
   logic          s_in_ready, s_out_valid, s_busy;
   logic [143:0]  s_dout0, s_dout4, held, expv;
   logic [3:0]    s_ovf0;
   logic          sat_on;

   function automatic logic [143:0] model(input logic [39:0] a, input logic [143:0] b, input int sh);
      logic [143:0] res;
      longint pa, pb, p, r;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         pa = longint'($signed(a[i*10 +: 10]));
         pb = longint'($signed(b[i*36 +: 36]));
         p  = pa * pb;
         r  = p;
         if (sh > 0)
            r = (p + (64'sd1 <<< (sh - 1))) >>> sh;
`ifdef KERNEL_MHSA_MUL_SAT_EN
         if (r > 64'sd34359738367)
            r = 64'sd34359738367;
         else if (r < -64'sd34359738368)
            r = -64'sd34359738368;
`endif
         res[i*36 +: 36] = r[35:0];
      end
      return res;
   endfunction

   task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rand_in();
      for (int i = 0; i < 4; i++) begin
         din0[i*10 +: 10] = 10'($urandom());
         din1[i*36 +: 36] = 36'({$urandom(), $urandom()});
      end
   endtask

   // One clock: sample at the falling edge, score the handshakes, return just after the rising edge.
   task automatic step();
      logic [143:0] e0, e4;
      @(negedge ap_clk);
      s_in_ready  = in_ready0;
      s_out_valid = out_valid0;
      s_busy      = busy0;
      s_dout0     = dout0;
      s_dout4     = dout4;
      s_ovf0      = ovf0;
      acc_flag    = in_valid && in_ready0;
      if (acc_flag) begin
         exp0_q.push_back(model(din0, din1, 0));
         exp4_q.push_back(model(din0, din1, 4));
      end
      if (out_valid0 && out_ready) begin
         if (exp0_q.size() == 0) begin
            nchecks++;
            nerr++;
            $error("FAIL sb_underflow: unexpected beat dout %h, no beat expected", dout0);
         end else begin
            e0 = exp0_q.pop_front();
            e4 = exp4_q.pop_front();
            chk("sb_dout_shift0", dout0, e0);
            chk("sb_dout_shift4", dout4, e4);
            chk("sb_valid_match", out_valid4, 1);
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
      end
      cyc++;
      @(posedge ap_clk);
      #1;
   endtask

   initial begin
`ifdef KERNEL_MHSA_MUL_SAT_EN
      sat_on = 1'b1;
`else
      sat_on = 1'b0;
`endif
      // Reset state
      #12;
      chk("rst_in_ready", in_ready0, 0);
      chk("rst_out_valid", out_valid0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_dout", dout0, 0);
      chk("rst_ovf", ovf0, 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;

      // Single beat 3 * -7, latency two cycles
      din0 = '0; din1 = '0;
      din0[9:0]  = 10'd3;
      din1[35:0] = 36'hFFFFFFFF9;
      in_valid = 1'b1;
      @(negedge ap_clk);
      chk("t1_in_ready", in_ready0, 1);
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      @(negedge ap_clk);
      chk("t1_valid_c1", out_valid0, 0);
      chk("t1_busy_c1", busy0, 1);
      @(posedge ap_clk); #1;
      @(negedge ap_clk);
      chk("t1_valid_c2", out_valid0, 1);
      expv = '0; expv[35:0] = 36'hFFFFFFFEB;
      chk("t1_dout", dout0, expv);
      expv = '0; expv[35:0] = 36'hFFFFFFFFF;
      chk("t1_dout_shift4", dout4, expv);
      @(posedge ap_clk); #1;
      @(negedge ap_clk);
      chk("t1_drained_valid", out_valid0, 0);
      chk("t1_drained_busy", busy0, 0);
      @(posedge ap_clk); #1;

      // 16 back-to-back random beats
      pops = 0; first_pop = -1; last_pop = -1;
      for (int i = 0; i < 16; i++) begin
         rand_in();
         in_valid = 1'b1;
         step();
         chk("stream_in_ready", acc_flag, 1);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 6 && exp0_q.size() != 0; i++) step();
      chk("stream_pops", pops, 16);
      chk("stream_contiguous", last_pop - first_pop, 15);
      chk("stream_sb_empty", exp0_q.size(), 0);

      // Five-cycle sink stall in the middle of a 10-beat stream
      pops = 0;
      begin
         int sent;
         sent = 0;
         rand_in();
         held = '0;
         for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 3 && c < 8);
            in_valid  = (sent < 10);
            step();
            if (acc_flag) begin
               sent++;
               rand_in();
            end
            if (c == 3) held = s_dout0;
            if (c >= 3 && c < 8) begin
               chk("stall_in_ready", s_in_ready, 0);
               chk("stall_out_valid", s_out_valid, 1);
               chk("stall_dout_hold", s_dout0, held);
            end
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         chk("stall_sent", sent, 10);
      end
      chk("stall_pops", pops, 10);
      chk("stall_sb_empty", exp0_q.size(), 0);

      // Rounding on the SHIFT=4 instance: 24 -> 2, -24 -> -1, 8 -> 1
      din0 = '0; din1 = '0;
      din0[9:0]   = 10'd3;    din1[35:0]   = 36'd8;
      din0[19:10] = 10'h3FD;  din1[71:36]  = 36'd8;
      din0[29:20] = 10'd1;    din1[107:72] = 36'd8;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("shift_valid_c1", s_out_valid, 0);
      step();
      chk("shift_valid_c2", s_out_valid, 1);
      expv = '0;
      expv[35:0]   = 36'd2;
      expv[71:36]  = 36'hFFFFFFFFF;
      expv[107:72] = 36'd1;
      chk("shift_round", s_dout4, expv);

      // Overflow: -512 * (2^35-1)
      din0 = '0; din1 = '0;
      din0[9:0]  = 10'h200;
      din1[35:0] = 36'h7FFFFFFFF;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("ovf_set_c1", s_ovf0, {3'b000, sat_on});
      step();
      expv = '0;
      expv[35:0] = sat_on ? 36'h800000000 : 36'h000000200;
      chk("ovf_dout", s_dout0, expv);
      chk("ovf_hold", s_ovf0, {3'b000, sat_on});
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      step();
      chk("ovf_cleared", s_ovf0, 0);
      // Clear and a new clamp in the same cycle: the set survives
      in_valid = 1'b1;
      ovf_clr  = 1'b1;
      step();
      in_valid = 1'b0;
      ovf_clr  = 1'b0;
      step();
      chk("ovf_set_wins", s_ovf0, {3'b000, sat_on});
      for (int i = 0; i < 4 && exp0_q.size() != 0; i++) step();
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;

      // Reset with two beats held in flight
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rand_in();
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      #2;
      ap_rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", out_valid0, 0);
      chk("mrst_busy", busy0, 0);
      chk("mrst_dout", dout0, 0);
      chk("mrst_in_ready", in_ready0, 0);
      exp0_q.delete();
      exp4_q.delete();
      @(negedge ap_clk);
      ap_rst_n  = 1'b1;
      out_ready = 1'b1;
      #1;
      rand_in();
      in_valid = 1'b1;
      #1;
      chk("mrst_first_ready", in_ready0, 1);
      exp0_q.push_back(model(din0, din1, 0));
      exp4_q.push_back(model(din0, din1, 4));
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      pops = 0;
      for (int i = 0; i < 5; i++) step();
      chk("mrst_single_beat", pops, 1);
      chk("mrst_sb_empty", exp0_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
      $fatal(1, "timeout");
   end

endmodule
